// File: rtl/fpmult_arbiter.sv
// Two-requester round-robin front end for a serial-load FP multiplier.
// Define FPARB_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT cycles with a NaN result.
module fpmult_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] opa0,
   input  logic [31:0] opb0,
   input  logic [31:0] opa1,
   input  logic [31:0] opb1,
   output logic        ack0,
   output logic        ack1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] result,
   output logic        err,
   output logic        busy,
   output logic        mul_start,
   output logic [31:0] mul_in,
   input  logic [31:0] mul_res,
   input  logic        mul_done
);

   typedef enum logic [2:0] {IDLE, START, GAP, LOAD_A, LOAD_B, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic        grant_sel;
   logic [31:0] opa_q, opb_q;
   logic [1:0]  done_cnt;
   logic        captured;
   logic        timed_out;

   // A tie goes to whoever was not served last; a lone request simply wins.
   assign grant_sel = (req0 && req1) ? ~last_grant : req1;

   // The multiplier raises doneFP for two cycles once the product is stable.
   assign captured = (state == WAIT) && mul_done && (done_cnt == 2'd1);

`ifdef FPARB_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       err_q;

   assign timed_out = (state == WAIT) && !captured && (to_cnt == TIMEOUT - 8'd1);
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         if (state == LOAD_B)
            to_cnt <= 8'd0;
         else if (state == WAIT)
            to_cnt <= to_cnt + 8'd1;
         err_q <= timed_out;
      end
   end
`else
   logic [7:0] unused_timeout;

   assign unused_timeout = TIMEOUT;
   assign timed_out      = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mul_done && (req0 || req1)) state_nxt = START;
         START:   state_nxt = GAP;
         GAP:     state_nxt = LOAD_A;
         LOAD_A:  state_nxt = LOAD_B;
         LOAD_B:  state_nxt = WAIT;
         WAIT:    if (captured || timed_out) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         opa_q      <= 32'd0;
         opb_q      <= 32'd0;
         result     <= 32'd0;
         done_cnt   <= 2'd0;
      end else begin
         if (state == IDLE && state_nxt == START) begin
            last_grant <= grant_sel;
            opa_q      <= grant_sel ? opa1 : opa0;
            opb_q      <= grant_sel ? opb1 : opb0;
         end
         if (state == LOAD_B)
            done_cnt <= 2'd0;
         else if (state == WAIT)
            done_cnt <= mul_done ? done_cnt + 2'd1 : 2'd0;
         if (captured)
            result <= mul_res;
         else if (timed_out)
            result <= 32'h7FC0_0000;
      end
   end

   assign ack0      = (state == START) && !last_grant;
   assign ack1      = (state == START) &&  last_grant;
   assign rvalid0   = (state == DONE)  && !last_grant;
   assign rvalid1   = (state == DONE)  &&  last_grant;
   assign busy      = (state != IDLE);
   assign mul_start = (state == START);

   always_comb begin
      mul_in = 32'd0;
      case (state)
         LOAD_A:  mul_in = opa_q;
         LOAD_B:  mul_in = opb_q;
         default: mul_in = 32'd0;
      endcase
   end

endmodule

// File: doc/fpmult_arbiter.md
FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd200, the maximum WAIT-state cycle count (used only when FPARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have these ports, clock and reset first:
 clk  in  1  single clock; all logic on posedge
 rst  in  1  reset, synchronous, active-high
 req0, req1  in  1  requester 0/1 asks for a multiply
 opa0, opb0, opa1, opb1  in  32  IEEE-754 single operands per requester
 ack0, ack1  out  1  one-cycle pulse when the operands of requester n are latched
 rvalid0, rvalid1  out  1  one-cycle pulse when the result for requester n is on result
 result  out  32  last captured product
 err  out  1  one-cycle timeout flag, coincident with rvalidn
 busy  out  1  high whenever state != IDLE
 mul_start  out  1  drives multiplier startFP
 mul_in  out  32  drives multiplier inBus
 mul_res  in  32  multiplier resBus
 mul_done  in  1  multiplier doneFP

Function
REQ-003 The FSM SHALL have states IDLE, START, GAP, LOAD_A, LOAD_B, WAIT and DONE; all outputs are decoded from state or registers (Moore).
REQ-004 In IDLE with mul_done=1 and any req high: grant one requester, latch its opa/opb into internal registers, record the grant, and go to START; otherwise stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: a lone request is granted; with req0=req1=1 the requester not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-006 req is sampled only in IDLE; requests arriving or dropping in other states are ignored; a req held after rvalid is a new request.
REQ-007 START: mul_start=1, ack of the granted requester=1, then GAP. GAP: mul_start=0, then LOAD_A.
REQ-008 LOAD_A: mul_in = latched A, then LOAD_B. LOAD_B: mul_in = latched B, then WAIT. In all other states mul_in=0.
REQ-009 WAIT SHALL count consecutive cycles with mul_done=1 (the count clears on mul_done=0 and on WAIT entry); on the second consecutive high cycle it captures mul_res into result and goes to DONE.
REQ-010 DONE: rvalid of the granted requester=1 for one cycle, then IDLE.
REQ-011 Latency for normal operands SHALL be 17 cycles from the IDLE grant cycle to rvalid; for special-case operands (NaN/inf/zero) it SHALL be 9 cycles.
REQ-012 result SHALL hold its value until the next capture; ack/rvalid/err are never high for both requesters at once.

Reset
REQ-013 On rst=1 at a clock edge, from any state including mid-operation: state=IDLE, last_grant=1, result=0, latched operands=0, WAIT counters=0, and every output=0; the aborted transaction produces no rvalid.
REQ-014 rst is shared with the multiplier, so both return to idle together; the first grant after reset needs mul_done=1.

Configuration
REQ-015 With FPARB_TIMEOUT_EN defined, an 8-bit counter SHALL run in WAIT. On reaching TIMEOUT, the FSM goes to DONE with result=32'h7FC00000 and err=1 alongside rvalid. Grants still wait for mul_done=1 in IDLE.
REQ-016 Without FPARB_TIMEOUT_EN, err SHALL be tied to 0, no counter is built, and WAIT lasts until completion is detected.

Verification
REQ-017 req0 with opa0=32'h40000000, opb0=32'h40400000 -> ack0 at cycle 1, rvalid0 at cycle 17, result=32'h40C00000, err=0.
REQ-018 req0=req1=1 held after reset with distinct operands -> requester 0 served first, then requester 1; with both still held, requester 0 again (strict alternation); never two acks in one cycle.
REQ-019 req1 with opa1=32'h7F800000 (inf), opb1=32'h00000000 -> rvalid1 at cycle 9, result=32'hFFC00000.
REQ-020 rst pulsed during WAIT -> all outputs 0 next cycle, no rvalid for the aborted job; a new req0 then completes normally in 17 cycles.
REQ-021 FPARB_TIMEOUT_EN defined, TIMEOUT=8'd20, bench multiplier model holds mul_done=0 -> rvalid with err=1 and result=32'h7FC00000 at WAIT cycle 20; no new grant until mul_done returns high.
